// File: rtl/bubble_sort_if.sv
// Stream interface for the bubble sort engine: block length and input words in,
// sorted words out with a qualifying valid strobe.
interface bubble_sort_if #(
  parameter int W = 32
);
  logic [31:0]  n;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic         out_valid;

  modport master (
    output n,
    output in_data,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  n,
    input  in_data,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/bubble_sort_fsm.sv
// Single-clock engine: load up to MAX_N words, bubble-sort them in place with one
// compare/swap per clock, then stream them out in ascending order.
module bubble_sort_fsm #(
  parameter int MAX_N = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  bubble_sort_if.slave bus
);

  localparam int CW = $clog2(MAX_N + 1);
  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SORT   = 3'd2;
  localparam logic [2:0] OUTPUT = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state;
  logic [W-1:0]  mem [MAX_N];
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] k;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q;

  // Combinational helpers for the current state's decisions.
  logic [CW-1:0] cnt_req;
  logic [IW-1:0] j_nxt;
  logic [W-1:0]  lo_word;
  logic [W-1:0]  hi_word;
  logic [CW-1:0] j_last;
  logic          need_swap;
  logic          pass_end;
  logic          sort_last;
  logic          load_last;
  logic          out_last;

  // NOTE: every signal driven here gets a value on every path so no latch is inferred.
  always_comb begin
    cnt_req   = (bus.n > 32'(MAX_N)) ? CW'(MAX_N) : CW'(bus.n);
    j_nxt     = j + IW'(1);
    lo_word   = mem[j];
    hi_word   = mem[j_nxt];
    j_last    = cnt - CW'(2) - CW'(i);
    pass_end  = (CW'(j) == j_last);
    // A single-word block has nothing to compare; it spends one idle SORT cycle.
    need_swap = (cnt != CW'(1)) && (lo_word > hi_word);
    sort_last = (cnt == CW'(1)) || ((CW'(i) == cnt - CW'(2)) && pass_end);
    load_last = (CW'(idx) == cnt - CW'(1));
    out_last  = (CW'(k) == cnt - CW'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, which the in-place swap relies on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= cnt_req;
          if (cnt_req != '0) begin
            idx   <= IW'(1);
            i     <= '0;
            j     <= '0;
            state <= (cnt_req == CW'(1)) ? SORT : LOAD;
          end
        end

        LOAD: begin
          idx <= idx + IW'(1);
          if (load_last) begin
            i     <= '0;
            j     <= '0;
            state <= SORT;
          end
        end

        SORT: begin
          if (sort_last) begin
            k     <= '0;
            state <= OUTPUT;
          end else if (pass_end) begin
            j <= '0;
            i <= i + IW'(1);
          end else begin
            j <= j_nxt;
          end
        end

        OUTPUT: begin
          out_data_q  <= mem[k];
          out_valid_q <= 1'b1;
          k           <= k + IW'(1);
          if (out_last) state <= DONE;
        end

        DONE: begin
          // Holds the last word on out_data until the next reset.
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the word array carries no reset; its contents are don't-care until
  // loaded, and leaving it out keeps it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state)
        IDLE: if (cnt_req != '0) mem[0] <= bus.in_data;
        LOAD: mem[idx] <= bus.in_data;
        SORT: begin
          if (need_swap) begin
            mem[j]     <= hi_word;
            mem[j_nxt] <= lo_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bubble_sort_fsm.sv
// Self-checking bench for bubble_sort_fsm: directed and random blocks compared
// against a queue-sort reference model, including exact output latency.
module tb_bubble_sort_fsm;

  localparam int MAX_N = 16;
  localparam int W     = 32;

  typedef logic [W-1:0] word_q_t[$];

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bubble_sort_if #(.W(W)) bus ();

  bubble_sort_fsm #(.MAX_N(MAX_N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the first min(n, MAX_N) words, sorted ascending.
  function automatic word_q_t model_sort(input word_q_t words, input int unsigned n_val);
    word_q_t     r;
    int unsigned eff;
    eff = (n_val > MAX_N) ? MAX_N : n_val;
    for (int w = 0; w < int'(eff); w++) r.push_back(words[w]);
    r.sort();
    return r;
  endfunction

  // Edge index (counted from the first edge with reset low) of the first valid word.
  function automatic int model_first_edge(input int unsigned n_val);
    int eff;
    int sort_cycles;
    eff         = (n_val > MAX_N) ? MAX_N : int'(n_val);
    sort_cycles = eff * (eff - 1) / 2;
    if (sort_cycles < 1) sort_cycles = 1;
    return eff + sort_cycles + 1;
  endfunction

  function automatic bit same(input word_q_t a, input word_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[x]) if (a[x] !== b[x]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one block (n with word 0, then the rest) and keeps feeding noise,
  // capturing every valid output word until out_valid falls; bounded.
  task automatic run_block(input int unsigned n_val, input word_q_t words,
                           output word_q_t got, output int first_edge);
    int e;
    e          = 0;
    got        = {};
    first_edge = -1;
    for (int c = 0; c < 400; c++) begin
      bus.n       = (e == 0) ? n_val : $urandom;
      bus.in_data = (e < int'(words.size())) ? words[e] : $urandom;
      @(posedge clk);
      #1 e++;
      if (bus.out_valid === 1'b1) begin
        if (first_edge < 0) first_edge = e;
        got.push_back(bus.out_data);
      end else if (got.size() > 0) begin
        break;
      end
    end
  endtask

  // Drives exactly words.size() load edges without watching the outputs.
  task automatic load_block(input int unsigned n_val, input word_q_t words);
    foreach (words[w]) begin
      bus.n       = (w == 0) ? n_val : $urandom;
      bus.in_data = words[w];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    bus.n  = 32'd5;
    for (int c = 0; c < 1000; c++) begin
      bus.in_data = $urandom;
      @(posedge clk);
      #1 total++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: out_valid=%b out_data=%0d, want 0/0",
                 c, bus.out_valid, bus.out_data);
      end
    end
  endtask

  task automatic test_sorted;
    word_q_t words, got, exp;
    int      first;
    apply_reset(2);
    words = {32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    exp   = model_sort(words, 5);
    run_block(5, words, got, first);
    total++;
    if (first !== model_first_edge(5)) begin
      bad++;
      $display("FAIL sorted_latency: got edge %0d, want %0d", first, model_first_edge(5));
    end
    total++;
    if (!same(got, exp)) begin
      bad++;
      $display("FAIL sorted_data: got %p, want %p", got, exp);
    end
    // DONE must keep out_valid low and hold the largest word, ignoring inputs.
    repeat (5) begin
      bus.n       = 32'd3;
      bus.in_data = $urandom;
      @(posedge clk);
      #1 total++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd15) begin
        bad++;
        $display("FAIL done_hold: out_valid=%b out_data=%0d, want 0/15",
                 bus.out_valid, bus.out_data);
      end
    end
  endtask

  task automatic test_vectors;
    word_q_t     cases[3];
    int unsigned ns[3];
    word_q_t     got, exp;
    int          first;
    cases[0] = {32'd9999, 32'd2, 32'd2350, 32'd3598, 32'd5346,
                32'd7891, 32'd3456, 32'd1234, 32'd2345, 32'd4576};
    cases[1] = {32'd11, 32'd12, 32'd13, 32'd14, 32'd15,
                32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    cases[2] = {32'd7, 32'd3, 32'd7, 32'd0};
    ns       = '{10, 10, 4};
    for (int t = 0; t < 3; t++) begin
      apply_reset(2);
      exp = model_sort(cases[t], ns[t]);
      run_block(ns[t], cases[t], got, first);
      total++;
      if (first !== model_first_edge(ns[t])) begin
        bad++;
        $display("FAIL vector%0d_latency: got edge %0d, want %0d",
                 t, first, model_first_edge(ns[t]));
      end
      total++;
      if (!same(got, exp)) begin
        bad++;
        $display("FAIL vector%0d_data: got %p, want %p", t, got, exp);
      end
    end
  endtask

  task automatic test_n_zero;
    word_q_t words, got, exp;
    int      valid_seen;
    int      first;
    apply_reset(2);
    valid_seen = 0;
    bus.n      = 32'd0;
    repeat (40) begin
      bus.in_data = $urandom;
      @(posedge clk);
      #1 if (bus.out_valid === 1'b1) valid_seen++;
    end
    total++;
    if (valid_seen !== 0) begin
      bad++;
      $display("FAIL n_zero_valid: out_valid high %0d cycles, want 0", valid_seen);
    end
    // The engine must still be sitting in IDLE, ready for a real block.
    words = {32'd30, 32'd10, 32'd20};
    exp   = model_sort(words, 3);
    run_block(3, words, got, first);
    total++;
    if (first !== model_first_edge(3) || !same(got, exp)) begin
      bad++;
      $display("FAIL n_zero_then_block: got edge %0d data %p, want edge %0d data %p",
               first, got, model_first_edge(3), exp);
    end
  endtask

  task automatic test_n_one;
    word_q_t words, got;
    int      first;
    apply_reset(2);
    words = {32'd42};
    run_block(1, words, got, first);
    total++;
    if (first !== 3 || got.size() != 1 || got[0] !== 32'd42) begin
      bad++;
      $display("FAIL n_one: got edge %0d data %p, want edge 3 data '{42}", first, got);
    end
  endtask

  task automatic test_clamp;
    word_q_t words, got, exp;
    int      first;
    apply_reset(2);
    words = {};
    for (int w = 0; w < 20; w++) words.push_back($urandom);
    exp = model_sort(words, 20);
    run_block(20, words, got, first);
    total++;
    if (first !== model_first_edge(20)) begin
      bad++;
      $display("FAIL clamp_latency: got edge %0d, want %0d", first, model_first_edge(20));
    end
    total++;
    if (!same(got, exp)) begin
      bad++;
      $display("FAIL clamp_data: got %0d words %p, want %0d words %p",
               got.size(), got, exp.size(), exp);
    end
  endtask

  task automatic test_reset_mid;
    word_q_t words, got, exp;
    int      first;
    int      waited;
    for (int phase = 0; phase < 2; phase++) begin
      apply_reset(2);
      words = {};
      for (int w = 0; w < 10; w++) words.push_back($urandom_range(1, 1000));
      load_block(10, words);
      if (phase == 0) begin
        repeat (7) @(posedge clk);
        #1;
      end else begin
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 200) begin
          @(posedge clk);
          #1 waited++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL mid_output_reach: out_valid=%b after %0d cycles, want 1",
                   bus.out_valid, waited);
        end
        @(posedge clk);
        #1;
      end
      reset = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1 total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
          bad++;
          $display("FAIL mid_reset phase%0d: out_valid=%b out_data=%0d, want 0/0",
                   phase, bus.out_valid, bus.out_data);
        end
      end
      #1 reset = 1'b0;
      words = {};
      for (int w = 0; w < 6; w++) words.push_back($urandom);
      exp = model_sort(words, 6);
      run_block(6, words, got, first);
      total++;
      if (first !== model_first_edge(6) || !same(got, exp)) begin
        bad++;
        $display("FAIL mid_reset_recover phase%0d: got edge %0d data %p, want edge %0d data %p",
                 phase, first, got, model_first_edge(6), exp);
      end
    end
  endtask

  task automatic test_random;
    word_q_t     words, got, exp;
    int unsigned n_val;
    int          first;
    for (int t = 0; t < 24; t++) begin
      apply_reset(2);
      n_val = (t % 6 == 5) ? $urandom_range(17, 24) : $urandom_range(1, MAX_N);
      words = {};
      for (int w = 0; w < int'(n_val); w++)
        words.push_back((t % 2 == 0) ? $urandom_range(0, 7) : $urandom);
      exp = model_sort(words, n_val);
      run_block(n_val, words, got, first);
      total++;
      if (first !== model_first_edge(n_val) || !same(got, exp)) begin
        bad++;
        $display("FAIL random%0d n=%0d: got edge %0d data %p, want edge %0d data %p",
                 t, n_val, first, got, model_first_edge(n_val), exp);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.n       = '0;
    bus.in_data = '0;
    test_reset();
    test_sorted();
    test_vectors();
    test_n_zero();
    test_n_one();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
